fetch_cycle: RTL

Instruction-fetch stage of the RV32I five-stage pipeline. Owns the PC, issues single-outstanding requests to instruction memory and drives the IF/ID pipeline register (`pc_d`, `pc4_d`, `instr`) consumed by the decode stage. Honors hazard-unit stall, branch/jump flush and redirect, and absorbs variable memory latency with a one-entry holding buffer.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/fetch_hold_buf.sv | 44 ++++
 rtl/fetch_cycle.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I pipeline types and constants
// FETCH_MISALIGN_CHECK_EN adds the FAULT fetch state.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_DROP  = 3'd2,
        ST_HOLD  = 3'd3
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        ST_FAULT = 3'd4
`endif
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry {pc, instr} buffer for responses arriving under stall
module fetch_hold_buf
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            rel,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic [XLEN-1:0] hold_pc,
    output logic [XLEN-1:0] hold_instr
);

    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;

    always_comb begin
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        if (load) begin
            hold_pc_d    = load_pc;
            hold_instr_d = load_instr;
        end else if (rel || clear) begin
            hold_pc_d    = '0;
            hold_instr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else begin
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign hold_pc    = hold_pc_q;
    assign hold_instr = hold_instr_q;

endmodule

// File: rtl/fetch_cycle.sv
// rtl/fetch_cycle.sv - RV32I instruction fetch stage driving the IF/ID register
// FETCH_MISALIGN_CHECK_EN: misaligned redirects raise a sticky fetch_fault and halt fetch.
module fetch_cycle
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            flush_d,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc4_d,
    output logic [XLEN-1:0] instr,
    output logic            valid_d,
    output logic            fetch_fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;

    logic [XLEN-1:0] tgt_pc, dlv_pc, dlv_instr, hold_pc, hold_instr;
    logic            issue, deliver, hold_load, hold_rel, hold_clear;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic bad_redirect;

    assign tgt_pc       = redirect_pc;
    assign bad_redirect = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign tgt_pc       = redirect_pc & ~XLEN'(3);
`endif

    fetch_hold_buf u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .rel        (hold_rel),
        .clear      (hold_clear),
        .load_pc    (req_pc_q),
        .load_instr (imem_rdata),
        .hold_pc    (hold_pc),
        .hold_instr (hold_instr)
    );

    always_comb begin
        state_d    = state_q;
        pc_f_d     = pc_f_q;
        req_pc_d   = req_pc_q;
        issue      = 1'b0;
        deliver    = 1'b0;
        dlv_pc     = req_pc_q;
        dlv_instr  = imem_rdata;
        hold_load  = 1'b0;
        hold_rel   = 1'b0;
        hold_clear = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d    = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (redirect) pc_f_d = tgt_pc;
                else          issue  = 1'b1;
            end
            ST_WAIT: begin
                if (!imem_rvalid) begin
                    if (redirect) begin
                        pc_f_d  = tgt_pc;
                        state_d = ST_DROP;
                    end
                end else if (redirect) begin
                    pc_f_d  = tgt_pc;
                    state_d = ST_IDLE;
                end else if (stall_f) begin
                    hold_load = 1'b1;
                    state_d   = ST_HOLD;
                end else begin
                    deliver = 1'b1;
                    issue   = 1'b1;
                end
            end
            ST_DROP: begin
                if (redirect)    pc_f_d  = tgt_pc;
                if (imem_rvalid) state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (redirect) begin
                    hold_clear = 1'b1;
                    pc_f_d     = tgt_pc;
                    state_d    = ST_IDLE;
                end else if (!stall_f) begin
                    deliver   = 1'b1;
                    dlv_pc    = hold_pc;
                    dlv_instr = hold_instr;
                    hold_rel  = 1'b1;
                    issue     = 1'b1;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            ST_FAULT: ;
`endif
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            req_pc_d = pc_f_q;
            pc_f_d   = pc_f_q + XLEN'(4);
            state_d  = ST_WAIT;
        end

`ifdef FETCH_MISALIGN_CHECK_EN
        // An outstanding response must still drain through DROP before halting.
        if (bad_redirect) begin
            fault_d = 1'b1;
            if (state_d != ST_DROP) state_d = ST_FAULT;
        end
        if (state_q == ST_DROP && imem_rvalid && fault_q) state_d = ST_FAULT;
`endif
    end

    // IF/ID priority: flush > stall > delivery > bubble
    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (flush_d || (!stall_f && !deliver)) begin
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (!stall_f) begin
            ifid_pc_d    = dlv_pc;
            ifid_instr_d = dlv_instr;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_f_q       <= RESET_PC;
            req_pc_q     <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            req_pc_q     <= req_pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end

    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign imem_req  = issue && !rst;
    assign imem_addr = imem_req ? pc_f_q : '0;
    assign pc_d      = ifid_pc_q;
    assign pc4_d     = ifid_pc_q + XLEN'(4) & {XLEN{ifid_valid_q}};
    assign instr     = ifid_instr_q;
    assign valid_d   = ifid_valid_q;

endmodule
